jtoutrun_subbridge: RTL

JTOUTRUN_SUBBRIDGE -- requirements
Module: jtoutrun_subbridge

---
 rtl/jtoutrun_subbridge.sv | 107 ++++++++++
 1 files changed

// File: rtl/jtoutrun_subbridge.sv
// Bridges main-CPU accesses into the sub-CPU shared window: requests the sub bus,
// waits for a stable grant, performs the access and holds DTACK until main_cs drops.
module jtoutrun_subbridge #(
  parameter int TIMEOUT = 1024,
  parameter int SETTLE  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        main_cs,
  input  logic        main_rnw,
  input  logic        sub_ok,
  input  logic [15:0] sub_din,
  output logic        sub_br,
  output logic [15:0] main_din,
  output logic        main_ok,
  output logic [7:0]  tout_cnt
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SETTLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [SW-1:0] settle_cnt;
  logic          timed_out;

  assign timed_out = (timer == TIMER_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      sub_br     <= 1'b0;
      main_ok    <= 1'b0;
      main_din   <= 16'h0000;
      tout_cnt   <= 8'd0;
      timer      <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (main_cs) begin
            state  <= ST_REQ;
            sub_br <= 1'b1;
            timer  <= '0;
          end
        end

        ST_REQ, ST_SETTLE, ST_ACCESS: begin
          timer <= timer + 1'b1;
          if (!main_cs) begin
            // Abort: release the bus without touching data or the timeout count
            state  <= ST_IDLE;
            sub_br <= 1'b0;
          end else if (state == ST_ACCESS && sub_ok) begin
            // Completion beats a coincident timeout
            state   <= ST_DONE;
            main_ok <= 1'b1;
            if (main_rnw) main_din <= sub_din;
          end else if (timed_out) begin
            state    <= ST_DONE;
            main_ok  <= 1'b1;
            main_din <= 16'hFFFF;
            if (tout_cnt != 8'hFF) tout_cnt <= tout_cnt + 8'd1;
          end else if (state == ST_REQ) begin
            if (sub_ok) begin
              state      <= ST_SETTLE;
              settle_cnt <= '0;
            end
          end else if (state == ST_SETTLE) begin
            if (!sub_ok) begin
              state <= ST_REQ;
            end else if (settle_cnt == SETTLE_LAST) begin
              state <= ST_ACCESS;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
        end

        ST_DONE: begin
          if (!main_cs) begin
            state   <= ST_IDLE;
            sub_br  <= 1'b0;
            main_ok <= 1'b0;
          end
        end

        default: begin
          state   <= ST_IDLE;
          sub_br  <= 1'b0;
          main_ok <= 1'b0;
        end
      endcase
    end
  end

endmodule
